// File: rtl/spdif_i2s_tx.sv
// S/PDIF-to-I2S master transmitter: stereo FIFO, fractional-NCO bit clock,
// 64-bit-per-frame I2S serialiser with mute on decoder fault or FIFO underrun.
module spdif_i2s_tx #(
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned PHASE_INC = 2684355,
  parameter int unsigned FIFO_AW   = 2,
  parameter int unsigned PREFILL   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [23:0]        sample_left,
  input  logic [23:0]        sample_right,
  input  logic               sample_ready,
  input  logic               fault,
  output logic               i2s_bclk,
  output logic               i2s_lrck,
  output logic               i2s_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               underrun,
  output logic               overflow
);

  localparam int unsigned      DEPTH       = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_PREFILL = (FIFO_AW + 1)'(PREFILL);

  typedef enum logic [1:0] {
    ST_MUTE,
    ST_PREFILL,
    ST_RUN
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 tick;
  logic                 fall;
  logic                 frame_end;
  logic [5:0]           bit_idx;
  logic [5:0]           bit_idx_nx;
  logic [4:0]           slot_pos;
  logic [4:0]           msb_ofs;
  logic [23:0]          left_word;
  logic [23:0]          right_word;
  logic [23:0]          cur_word;
  logic                 ser_bit;
  logic [47:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic                 push_req;
  logic                 push_ok;
  logic                 pop;
  logic                 drop;

  assign acc_sum    = {1'b0, acc} + (ACC_WIDTH + 1)'(PHASE_INC);
  assign tick       = acc_sum[ACC_WIDTH];
  assign fall       = tick & i2s_bclk;
  assign frame_end  = fall && (bit_idx == 6'd63);
  assign bit_idx_nx = bit_idx + 6'd1;

  // Bit launched at a falling edge belongs to the slot position being entered.
  always_comb begin
    slot_pos = bit_idx_nx[4:0];
    msb_ofs  = 5'd24 - slot_pos;
    cur_word = bit_idx_nx[5] ? right_word : left_word;
    ser_bit  = 1'b0;
    if (!fault && slot_pos >= 5'd1 && slot_pos <= 5'd24)
      ser_bit = cur_word[msb_ofs];
  end

  // Empty/full are judged on the registered level; a pop frees room for a same-cycle push.
  always_comb begin
    push_req = sample_ready && !fault && (state != ST_MUTE);
    pop      = 1'b0;
    if (!fault && frame_end && fifo_level != '0) begin
      if (state == ST_RUN)
        pop = 1'b1;
      else if (state == ST_PREFILL && fifo_level >= LVL_PREFILL)
        pop = 1'b1;
    end
    push_ok = push_req && ((fifo_level != LVL_FULL) || pop);
    drop    = push_req && (fifo_level == LVL_FULL) && !pop;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {sample_right, sample_left};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_MUTE;
      acc        <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrck   <= 1'b0;
      i2s_data   <= 1'b0;
      bit_idx    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      left_word  <= '0;
      right_word <= '0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      acc <= acc_sum[ACC_WIDTH-1:0];
      if (tick)
        i2s_bclk <= ~i2s_bclk;
      if (fall) begin
        bit_idx  <= bit_idx_nx;
        i2s_lrck <= bit_idx_nx[5];
        i2s_data <= ser_bit;
      end
      underrun <= 1'b0;
      overflow <= drop;

      if (fault) begin
        state      <= ST_MUTE;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        left_word  <= '0;
        right_word <= '0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop) begin
          rd_ptr                  <= rd_ptr + FIFO_AW'(1);
          {right_word, left_word} <= mem[rd_ptr];
        end
        fifo_level <= fifo_level + (FIFO_AW + 1)'(push_ok) - (FIFO_AW + 1)'(pop);
        if (frame_end) begin
          case (state)
            ST_MUTE:    state <= ST_PREFILL;
            ST_PREFILL: if (pop) state <= ST_RUN;
            ST_RUN: begin
              if (!pop) begin
                underrun   <= 1'b1;
                left_word  <= '0;
                right_word <= '0;
                state      <= ST_PREFILL;
              end
            end
            default:    state <= ST_MUTE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spdif_i2s_tx.sv
// Randomised bench for spdif_i2s_tx against an arithmetic NCO / queue-based reference model.
module tb_spdif_i2s_tx;

  localparam int unsigned ACC_WIDTH = 24;
  localparam int unsigned PHASE_INC = 2684355;
  localparam int unsigned FIFO_AW   = 2;
  localparam int unsigned PREFILL   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] sample_left = '0;
  logic [23:0] sample_right = '0;
  logic        sample_ready = 1'b0;
  logic        fault = 1'b0;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_data;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic        overflow;

  spdif_i2s_tx #(
    .ACC_WIDTH(ACC_WIDTH),
    .PHASE_INC(PHASE_INC),
    .FIFO_AW  (FIFO_AW),
    .PREFILL  (PREFILL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_left (sample_left),
    .sample_right(sample_right),
    .sample_ready(sample_ready),
    .fault       (fault),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrck    (i2s_lrck),
    .i2s_data    (i2s_data),
    .fifo_level  (fifo_level),
    .underrun    (underrun),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          checking = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Half-period ticks after k cycles is floor(k*INC / 2^ACC_WIDTH); everything else follows.
  typedef enum {M_MUTE, M_PREFILL, M_RUN} mstate_t;
  longint      m_k = 0;
  mstate_t     m_state = M_MUTE;
  logic [47:0] m_q[$];
  logic [23:0] m_l = '0;
  logic [23:0] m_r = '0;
  logic        m_data = 1'b0;
  logic        m_under = 1'b0;
  logic        m_over = 1'b0;

  function automatic longint ticks(input longint k);
    return (k * longint'(PHASE_INC)) >> ACC_WIDTH;
  endfunction

  function automatic bit boundary_next();
    longint t0, t1;
    t0 = ticks(m_k);
    t1 = ticks(m_k + 1);
    return (t1 != t0) && (t0 % 2 == 1) && ((t1 / 2) % 64 == 0);
  endfunction

  longint      mt0, mt1, mf;
  bit          mfall, mbnd, mpush, mpop;
  int          mlvl, mp;
  logic [23:0] mword;

  always @(posedge clk) begin
    if (rst) begin
      m_k = 0;
      m_q.delete();
      m_state = M_MUTE;
      m_l = '0;
      m_r = '0;
      m_data = 1'b0;
      m_under = 1'b0;
      m_over = 1'b0;
    end else begin
      mt0 = ticks(m_k);
      m_k++;
      mt1 = ticks(m_k);
      mfall = (mt1 != mt0) && (mt0 % 2 == 1);
      mf = mt1 / 2;
      mbnd = mfall && (mf % 64 == 0);
      m_under = 1'b0;
      m_over = 1'b0;
      if (fault) begin
        if (mfall) m_data = 1'b0;
        m_q.delete();
        m_state = M_MUTE;
        m_l = '0;
        m_r = '0;
      end else begin
        if (mfall) begin
          mp = int'(mf % 32);
          mword = (mf % 64 >= 32) ? m_r : m_l;
          m_data = (mp >= 1 && mp <= 24) ? mword[24 - mp] : 1'b0;
        end
        mlvl = m_q.size();
        mpush = sample_ready && (m_state != M_MUTE);
        mpop = mbnd && (mlvl > 0) &&
               ((m_state == M_PREFILL && mlvl >= int'(PREFILL)) || m_state == M_RUN);
        if (mbnd) begin
          case (m_state)
            M_MUTE:    m_state = M_PREFILL;
            M_PREFILL: if (mlvl >= int'(PREFILL)) m_state = M_RUN;
            M_RUN: begin
              if (mlvl == 0) begin
                m_under = 1'b1;
                m_l = '0;
                m_r = '0;
                m_state = M_PREFILL;
              end
            end
            default: ;
          endcase
        end
        if (mpop) {m_r, m_l} = m_q.pop_front();
        if (mpush) begin
          if (m_q.size() < 4) m_q.push_back({sample_right, sample_left});
          else m_over = 1'b1;
        end
      end
    end
  end

  longint cmp_t;
  always @(negedge clk) begin
    if (checking) begin
      cmp_t = ticks(m_k);
      chk("bclk", i2s_bclk, 64'(cmp_t % 2));
      chk("lrck", i2s_lrck, ((cmp_t / 2) % 64 >= 32) ? 64'd1 : 64'd0);
      chk("data", i2s_data, 64'(m_data));
      chk("fifo_level", fifo_level, 64'(m_q.size()));
      chk("underrun", underrun, 64'(m_under));
      chk("overflow", overflow, 64'(m_over));
    end
  end

  // Frame capture as a DAC would see it: sample data on BCLK rising.
  bit          cap_arm = 0;
  bit          cap_done = 0;
  bit          cap_go = 0;
  int unsigned cap_n = 0;
  logic [63:0] cap_bits = '0;
  logic        prev_bclk = 1'b0;
  logic        prev_lr = 1'b1;

  always @(negedge clk) begin
    if (!cap_arm) begin
      cap_done = 0;
      cap_go = 0;
    end
    if (i2s_bclk && !prev_bclk) begin
      if (cap_arm && !cap_done) begin
        if (!cap_go && !i2s_lrck && prev_lr) begin
          cap_go = 1;
          cap_n = 0;
        end
        if (cap_go) begin
          cap_bits = {cap_bits[62:0], i2s_data};
          cap_n++;
          if (cap_n == 64) begin
            cap_done = 1;
            cap_go = 0;
          end
        end
      end
      prev_lr = i2s_lrck;
    end
    prev_bclk = i2s_bclk;
  end

  // ---------------- stimulus ----------------
  int unsigned push_period = 0;
  int unsigned push_cnt = 0;
  bit          push_rand = 0;
  logic [23:0] fix_l = '0;
  logic [23:0] fix_r = '0;

  task automatic cyc();
    @(negedge clk);
    sample_ready = 1'b0;
    if (push_period != 0) begin
      push_cnt++;
      if (push_cnt >= push_period) begin
        push_cnt = 0;
        sample_ready = 1'b1;
        if (push_rand) begin
          sample_left  = 24'($urandom);
          sample_right = 24'($urandom);
          push_period  = $urandom_range(760, 840);
        end else begin
          sample_left  = fix_l;
          sample_right = fix_r;
        end
      end
    end
  endtask

  task automatic next_rise(output int unsigned waited);
    logic pb;
    waited = 0;
    do begin
      pb = i2s_bclk;
      cyc();
      waited++;
    end while (!(i2s_bclk && !pb) && waited < 64);
  endtask

  task automatic wait_bnd();
    int unsigned g;
    g = 0;
    while (!boundary_next() && g < 2000) begin
      cyc();
      g++;
    end
    if (g >= 2000) chk("boundary_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_bclk"}, i2s_bclk, 64'd0);
    chk({tag, "_lrck"}, i2s_lrck, 64'd0);
    chk({tag, "_data"}, i2s_data, 64'd0);
    chk({tag, "_level"}, fifo_level, 64'd0);
    chk({tag, "_underrun"}, underrun, 64'd0);
    chk({tag, "_overflow"}, overflow, 64'd0);
  endtask

  initial begin
    int unsigned w, total, cnt, guard, fault_left;
    bit seen;

    repeat (3) cyc();
    rst = 1'b0;
    chk_reset_state("reset");
    checking = 1;

    // Bit clock: 1000 periods must take 12500 clk on average.
    next_rise(w);
    total = 0;
    repeat (1000) begin
      next_rise(w);
      total += w;
    end
    chk_rng("bclk_1000_periods", total, 12499, 12501);

    // Fixed-pattern frame at the nominal 48 kHz push rate.
    fix_l = 24'hABCDEF;
    fix_r = 24'h123456;
    push_cnt = 799;
    push_period = 800;
    repeat (4000) cyc();
    cap_arm = 1;
    guard = 0;
    while (!cap_done && guard < 3000) begin
      cyc();
      guard++;
    end
    chk("frame_serial", cap_bits, {1'b0, 24'hABCDEF, 7'd0, 1'b0, 24'h123456, 7'd0});
    cap_arm = 0;

    // Underrun: stop feeding while running.
    push_period = 0;
    cnt = 0;
    repeat (3500) begin
      cyc();
      if (underrun) cnt++;
    end
    chk("underrun_pulses", cnt, 1);
    chk("underrun_level", fifo_level, 0);
    fix_l = 24'h5A5A5A;
    fix_r = 24'hA5A5A5;
    push_cnt = 799;
    push_period = 800;
    seen = 0;
    repeat (4000) begin
      cyc();
      if (i2s_data) seen = 1;
    end
    chk("audio_resumes", seen, 1);

    // Fault in RUN with three entries queued.
    push_period = 0;
    guard = 0;
    while (guard < 40) begin
      cyc();
      if (m_q.size() >= 3) break;
      sample_ready = 1'b1;
      sample_left  = 24'($urandom);
      sample_right = 24'($urandom);
      guard++;
    end
    chk("fault_pre_level", fifo_level, 3);
    fault = 1'b1;
    cyc();
    chk("fault_flush_level", fifo_level, 0);
    sample_ready = 1'b1;
    cyc();
    chk("fault_push_ignored", fifo_level, 0);
    repeat (20) cyc();
    repeat (30) begin
      cyc();
      chk("fault_data_zero", i2s_data, 0);
    end
    fault = 1'b0;

    // Overflow: five back-to-back pushes just after entering PREFILL.
    wait_bnd();
    cyc();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      sample_ready = 1'b1;
      sample_left  = 24'h100000 + 24'(i);
      sample_right = (i == 4) ? 24'hDEAD05 : 24'h200000 + 24'(i);
      cyc();
      if (overflow) cnt++;
    end
    cyc();
    if (overflow) cnt++;
    chk("overflow_level", fifo_level, 4);
    chk("overflow_pulses", cnt, 1);

    // Simultaneous push and pop while full.
    wait_bnd();
    cyc();
    sample_ready = 1'b1;
    sample_left  = 24'h0F0F0F;
    sample_right = 24'hF0F0F0;
    cyc();
    chk("refill_level", fifo_level, 4);
    wait_bnd();
    sample_ready = 1'b1;
    sample_left  = 24'h777777;
    sample_right = 24'h888888;
    cyc();
    chk("simul_level", fifo_level, 4);
    chk("simul_no_overflow", overflow, 0);

    // Randomised traffic with faults, extra pushes and one mid-frame reset.
    push_rand = 1;
    push_cnt = 0;
    push_period = 800;
    fault_left = 0;
    for (int c = 0; c < 35000; c++) begin
      cyc();
      if (fault_left > 0) begin
        fault_left--;
        if (fault_left == 0) fault = 1'b0;
      end else if ($urandom_range(0, 6999) == 0) begin
        fault = 1'b1;
        fault_left = $urandom_range(1, 1500);
      end
      if ($urandom_range(0, 2999) == 0) begin
        sample_ready = 1'b1;
        sample_left  = 24'($urandom);
        sample_right = 24'($urandom);
      end
      if (c == 17321) begin
        rst = 1'b1;
        cyc();
        chk_reset_state("midreset");
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

endmodule

// File: doc/spdif_i2s_tx.md
# spdif_i2s_tx

Serialises the stereo 24-bit samples produced by the S/PDIF decoder onto a standard I2S bus (BCLK, LRCK, SDATA) in master mode, from the same 38.4 MHz system clock. It sits directly downstream of `spdif_decode` and is the last stage before the external DAC.
- A small stereo FIFO absorbs jitter between the recovered S/PDIF frame rate and the locally generated I2S rate.
- A fractional NCO produces BCLK = 64·fs.
- Output is muted on decoder fault or FIFO underrun.

## Interface
Parameters:
- `ACC_WIDTH`, 24: NCO phase accumulator width.
- `PHASE_INC`, 2684355: accumulator increment. Equals round(2·BCLK/f_clk·2^ACC_WIDTH), giving 3.072 MHz BCLK (fs = 48 kHz) at 38.4 MHz.
- `FIFO_AW`, 2: FIFO address width. Depth = 2^FIFO_AW stereo entries (4).
- `PREFILL`, 2: entries required before leaving PREFILL.

Ports:
- `clk` in 1: system clock, 38.4 MHz.
- `rst` in 1: synchronous, active-high reset.
- `sample_left` in 24: left sample from decoder, two's complement.
- `sample_right` in 24: right sample from decoder.
- `sample_ready` in 1: one-cycle pulse; left/right pair valid this cycle.
- `fault` in 1: decoder fault level.
- `i2s_bclk` out 1: bit clock.
- `i2s_lrck` out 1: word select; 0 = left, 1 = right.
- `i2s_data` out 1: serial data, MSB first.
- `fifo_level` out FIFO_AW+1: current FIFO occupancy.
- `underrun` out 1: one-cycle pulse at a frame start in RUN with the FIFO empty.
- `overflow` out 1: one-cycle pulse when a push is dropped because the FIFO is full.

## Operation
- **NCO:** `acc <= acc + PHASE_INC` every cycle, modulo 2^ACC_WIDTH. A carry out is a half-period `tick`. On each tick `i2s_bclk` toggles (registered).
- **Falling edges:** edge = tick while `i2s_bclk` = 1. At each falling edge, `bit_idx` (6 bits, 0..63) increments with wrap; `i2s_lrck` and `i2s_data` update on the same clk edge. The DAC samples SDATA on BCLK rising.
- **Slot mapping:** `i2s_lrck` = `bit_idx[5]`. Slot position p = `bit_idx[4:0]`.
  - p = 0: data 0 (I2S one-bit delay).
  - p = 1..24: data = word[24−p], MSB at p = 1.
  - p = 25..31: data 0.
  - Word is the left register when `lrck` = 0, right register when 1.
- **Frame boundary:** the falling edge where `bit_idx` wraps 63→0. Left/right output registers reload only here.
- **FIFO:** 48-bit entries {right, left}.
  - Push on `sample_ready && !fault && state != MUTE`.
  - Push when full: entry dropped, `overflow` pulses.
  - Push and pop in the same cycle at full: both succeed, level unchanged.
- **State machine** (evaluated at frame boundaries, except fault/reset):
  - MUTE: FIFO held empty, output registers zero. If `fault` = 0 at a frame boundary → PREFILL.
  - PREFILL: pushes accepted, outputs zero. If `fifo_level` ≥ PREFILL at a frame boundary → pop into output registers, go RUN.
  - RUN: pop at each frame boundary.
    - FIFO empty at that boundary: load zeros, pulse `underrun`, go PREFILL.
    - Empty is judged on the registered level, so a same-cycle push does not prevent underrun; that push is still stored.
  - Any state: `fault` = 1 → MUTE next cycle, FIFO flushed, output registers zeroed immediately. Any word mid-serialisation continues as zeros.
- BCLK and LRCK run continuously in all states. Only data is muted.

## Timing
- **Reset values:** `acc`=0, `i2s_bclk`=0, `i2s_lrck`=0, `i2s_data`=0, `bit_idx`=0, FIFO empty, `fifo_level`=0, state MUTE, `underrun`=0, `overflow`=0. Output registers are 0.
- **Reset mid-frame:** everything returns to the above on the next clk edge. The first BCLK rise follows the first tick.
- **BCLK period:** average 2^ACC_WIDTH·2/PHASE_INC ≈ 12.5 clk. Each half-period is 6 or 7 clk.
- **Frame:** 64 BCLK periods, 800 clk on average.
- **Latency:**
  - `sample_ready` to `fifo_level` increment: 1 clk.
  - Pop to MSB on `i2s_data`: one BCLK falling edge after the frame boundary.
- `underrun` and `overflow` are single-clk pulses, registered.
- `fault` assertion to output registers zero: 1 clk. `fault` deassertion to audio: at least two frame boundaries plus PREFILL pushes.

## Test plan
- **Reset:** assert `rst` mid-frame → all outputs 0 the next cycle and state MUTE. BCLK averages 12.5 clk over 1000 periods.
- **Single-frame serialisation:** `fault`=0, push L=0xABCDEF, R=0x123456 at the 48 kHz rate → after PREFILL:
  - `lrck`=0 slot carries 0, then 101010111100110111101111, then seven 0s.
  - `lrck`=1 slot carries 0, then 000100100011010001010110, then seven 0s.
- **Underrun:** stop `sample_ready` in RUN → `underrun` pulses once at the first empty frame boundary, `i2s_data` stays 0, and state is PREFILL. Resume pushes → audio returns after 2 entries.
- **Overflow:** push 5 pairs in consecutive cycles in PREFILL → `fifo_level`=4, one `overflow` pulse, and the 5th pair is never output.
- **Fault:** raise `fault` in RUN with `fifo_level`=3 → next cycle `fifo_level`=0, data 0, and pushes ignored. Drop `fault` → MUTE, then PREFILL, then RUN.
- **Simultaneous push/pop:** at full with `sample_ready` on the frame-boundary cycle → level stays 4, no `overflow`.
